// File: rtl/shot_judge.sv
// Shot judge: synchronises both fire buttons, applies per-player cooldown, scores hits and runs the round FSM.
// Ports: Clk/Reset, frame_tick, restart, fire1/fire2 (async), S1/S2 -> score1/2, bird_hit, hit_by, flash, cd1/2, game_over, winner.
// Latency: fire level sampled at edge k is judged and registered at edge k+2; no backpressure, shots outside PLAY or in cooldown are dropped.
module shot_judge #(
    parameter int WIN_SCORE       = 10,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int FLASH_FRAMES    = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic       fire1,
    input  logic       fire2,
    input  logic       S1,
    input  logic       S2,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic       bird_hit,
    output logic [1:0] hit_by,
    output logic       flash,
    output logic       cd1,
    output logic       cd2,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        HIT_FLASH = 2'd1,
        OVER      = 2'd2
    } state_t;

    state_t     state, state_nxt;

    logic       f1_m, f1_s, f1_q;
    logic       f2_m, f2_s, f2_q;
    logic [7:0] cnt1, cnt2, flash_cnt;

    logic       shot1, shot2;
    logic       acc1, acc2;
    logic       hit1, hit2;
    logic       win1, win2;
    logic       do_restart;

    // One pulse per press: the rising edge of the synchronised level.
    assign shot1 = f1_s & ~f1_q;
    assign shot2 = f2_s & ~f2_q;

    assign acc1 = (state == PLAY) && shot1 && (cnt1 == 8'd0);
    assign acc2 = (state == PLAY) && shot2 && (cnt2 == 8'd0);

    // P1 has priority: a simultaneous P2 hit is treated as a miss.
    assign hit1 = acc1 & S1;
    assign hit2 = acc2 & S2 & ~hit1;

    assign win1 = (score1 + 8'd1) == 8'(WIN_SCORE);
    assign win2 = (score2 + 8'd1) == 8'(WIN_SCORE);

    assign do_restart = (state == OVER) && restart;

    assign cd1 = (cnt1 != 8'd0);
    assign cd2 = (cnt2 != 8'd0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= PLAY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        flash     = 1'b0;
        game_over = 1'b0;
        case (state)
            PLAY: begin
                if (hit1) begin
                    state_nxt = win1 ? OVER : HIT_FLASH;
                end else if (hit2) begin
                    state_nxt = win2 ? OVER : HIT_FLASH;
                end
            end
            HIT_FLASH: begin
                flash = 1'b1;
                if (frame_tick && (flash_cnt == 8'd1)) begin
                    state_nxt = PLAY;
                end
            end
            OVER: begin
                game_over = 1'b1;
                if (restart) begin
                    state_nxt = PLAY;
                end
            end
            default: state_nxt = PLAY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            f1_m      <= 1'b0;
            f1_s      <= 1'b0;
            f1_q      <= 1'b0;
            f2_m      <= 1'b0;
            f2_s      <= 1'b0;
            f2_q      <= 1'b0;
            cnt1      <= 8'd0;
            cnt2      <= 8'd0;
            flash_cnt <= 8'd0;
            score1    <= 8'd0;
            score2    <= 8'd0;
            bird_hit  <= 1'b0;
            hit_by    <= 2'b00;
            winner    <= 2'b00;
        end else begin
            f1_m <= fire1;
            f1_s <= f1_m;
            f1_q <= f1_s;
            f2_m <= fire2;
            f2_s <= f2_m;
            f2_q <= f2_s;

            // Load beats a coincident frame_tick decrement.
            if (do_restart) begin
                cnt1 <= 8'd0;
            end else if (acc1) begin
                cnt1 <= 8'(COOLDOWN_FRAMES);
            end else if (frame_tick && cnt1 != 8'd0) begin
                cnt1 <= cnt1 - 8'd1;
            end

            if (do_restart) begin
                cnt2 <= 8'd0;
            end else if (acc2) begin
                cnt2 <= 8'(COOLDOWN_FRAMES);
            end else if (frame_tick && cnt2 != 8'd0) begin
                cnt2 <= cnt2 - 8'd1;
            end

            if (state == PLAY && state_nxt == HIT_FLASH) begin
                flash_cnt <= 8'(FLASH_FRAMES);
            end else if (state == HIT_FLASH && frame_tick && flash_cnt != 8'd0) begin
                flash_cnt <= flash_cnt - 8'd1;
            end

            bird_hit <= hit1 | hit2;

            if (do_restart) begin
                score1 <= 8'd0;
                score2 <= 8'd0;
                hit_by <= 2'b00;
                winner <= 2'b00;
            end else if (hit1) begin
                score1 <= score1 + 8'd1;
                hit_by <= 2'b01;
                if (win1) winner <= 2'b01;
            end else if (hit2) begin
                score2 <= score2 + 8'd1;
                hit_by <= 2'b10;
                if (win2) winner <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_shot_judge.sv
// Testbench for shot_judge: directed reset/held-button prologue followed by randomized play,
// every output compared each cycle against a game-level reference model.
module tb_shot_judge;

    localparam int WIN = 3;
    localparam int CDF = 5;
    localparam int FLF = 6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       restart = 1'b0;
    logic       fire1 = 1'b0;
    logic       fire2 = 1'b0;
    logic       S1 = 1'b0;
    logic       S2 = 1'b0;
    logic [7:0] score1, score2;
    logic       bird_hit, flash, cd1, cd2, game_over;
    logic [1:0] hit_by, winner;

    shot_judge #(
        .WIN_SCORE      (WIN),
        .COOLDOWN_FRAMES(CDF),
        .FLASH_FRAMES   (FLF)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .restart   (restart),
        .fire1     (fire1),
        .fire2     (fire2),
        .S1        (S1),
        .S2        (S2),
        .score1    (score1),
        .score2    (score2),
        .bird_hit  (bird_hit),
        .hit_by    (hit_by),
        .flash     (flash),
        .cd1       (cd1),
        .cd2       (cd2),
        .game_over (game_over),
        .winner    (winner)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = playing, 1 = flashing, 2 = game over.
    // hist[0] is the fire level seen at the previous edge, hist[1] two edges ago, etc.
    int m_phase, m_s1, m_s2, m_cd1, m_cd2, m_fl, m_win, m_hb;
    bit m_bh;
    bit h1[3];
    bit h2[3];

    task automatic model_step();
        bit p1, p2, a1, a2, k1, k2;
        if (Reset) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_cd1 = 0; m_cd2 = 0;
            m_fl = 0; m_win = 0; m_hb = 0; m_bh = 0;
            for (int j = 0; j < 3; j++) begin
                h1[j] = 0;
                h2[j] = 0;
            end
            return;
        end
        // A press is judged two edges after it is first seen, if it was low the edge before.
        p1 = h1[1] && !h1[2];
        p2 = h2[1] && !h2[2];
        h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = fire1;
        h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = fire2;

        a1 = (m_phase == 0) && p1 && (m_cd1 == 0);
        a2 = (m_phase == 0) && p2 && (m_cd2 == 0);
        k1 = a1 && S1;
        k2 = a2 && S2 && !k1;
        m_bh = 0;

        if (frame_tick && m_cd1 > 0) m_cd1--;
        if (frame_tick && m_cd2 > 0) m_cd2--;
        if (a1) m_cd1 = CDF;
        if (a2) m_cd2 = CDF;

        case (m_phase)
            0: begin
                if (k1) begin
                    m_s1++; m_bh = 1; m_hb = 1;
                    if (m_s1 == WIN) begin m_phase = 2; m_win = 1; end
                    else begin m_phase = 1; m_fl = FLF; end
                end else if (k2) begin
                    m_s2++; m_bh = 1; m_hb = 2;
                    if (m_s2 == WIN) begin m_phase = 2; m_win = 2; end
                    else begin m_phase = 1; m_fl = FLF; end
                end
            end
            1: begin
                if (frame_tick) begin
                    m_fl--;
                    if (m_fl == 0) m_phase = 0;
                end
            end
            default: begin
                if (restart) begin
                    m_s1 = 0; m_s2 = 0; m_win = 0; m_hb = 0;
                    m_cd1 = 0; m_cd2 = 0; m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic drive(input int i);
        if (i < 3) begin
            Reset = 1; fire1 = 0; fire2 = 0; S1 = 0; S2 = 0;
            frame_tick = 0; restart = 0;
        end else if (i < 110) begin
            // Held button: exactly one shot expected, then a full flash and cooldown.
            Reset = 0; fire1 = 1; S1 = 1; fire2 = 0; S2 = 0;
            frame_tick = (i % 3 == 0); restart = 0;
        end else if (i < 112) begin
            fire1 = 0; frame_tick = 0;
        end else begin
            if ($urandom_range(7) == 0) begin
                fire1 = ~fire1;
                fire2 = fire1;
            end else begin
                if ($urandom_range(3) == 0) fire1 = ~fire1;
                if ($urandom_range(3) == 0) fire2 = ~fire2;
            end
            S1 = 1'($urandom_range(1));
            S2 = 1'($urandom_range(1));
            frame_tick = ($urandom_range(2) == 0);
            restart = ($urandom_range(7) == 0);
            Reset = ($urandom_range(399) == 0);
        end
    endtask

    initial begin
        model_step();
        for (int i = 0; i < 6000; i++) begin
            @(negedge Clk);
            drive(i);
            @(posedge Clk);
            model_step();
            #1;
            chk("score1",    32'(score1),    32'(m_s1));
            chk("score2",    32'(score2),    32'(m_s2));
            chk("bird_hit",  32'(bird_hit),  32'(m_bh));
            chk("hit_by",    32'(hit_by),    32'(m_hb));
            chk("flash",     32'(flash),     32'(m_phase == 1));
            chk("cd1",       32'(cd1),       32'(m_cd1 != 0));
            chk("cd2",       32'(cd2),       32'(m_cd2 != 0));
            chk("game_over", 32'(game_over), 32'(m_phase == 2));
            chk("winner",    32'(winner),    32'(m_win));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
